// File: rtl/sockit_ghrd_button_irq_servicer.sv
// Purpose: Avalon-MM master servicing a button PIO (irq_mask setup, edge_capture read/clear, level snapshot) into an event FIFO.
// Latency: pio_irq seen in IDLE at cycle t -> event at FIFO head (evt_valid) at t+5 when the FIFO is empty.
// Backpressure: evt_valid/evt_ready pop; a full FIFO without a same-cycle pop drops the event and bumps overflow_cnt (saturating).
// Optional feature macro: BUTTON_SVC_TIMESTAMP_EN (free-running timestamp captured per event on evt_time).
module sockit_ghrd_button_irq_servicer #(
  parameter int              WIDTH      = 4,
  parameter int              FIFO_DEPTH = 8,
  parameter logic [WIDTH-1:0] MASK_INIT = {WIDTH{1'b1}},
  parameter int              TS_WIDTH   = 16
) (
  input  logic                clk,
  input  logic                reset,
  output logic [1:0]          pio_address,
  output logic                pio_chipselect,
  output logic                pio_write_n,
  output logic [31:0]         pio_writedata,
  input  logic [31:0]         pio_readdata,
  input  logic                pio_irq,
  input  logic [WIDTH-1:0]    mask_value,
  input  logic                mask_load,
  output logic                evt_valid,
  input  logic                evt_ready,
  output logic [WIDTH-1:0]    evt_edges,
  output logic [WIDTH-1:0]    evt_levels,
  output logic [TS_WIDTH-1:0] evt_time,
  output logic [7:0]          overflow_cnt,
  output logic                busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);
`ifdef BUTTON_SVC_TIMESTAMP_EN
  localparam int EW = 2*WIDTH + TS_WIDTH;
`else
  localparam int EW = 2*WIDTH;
`endif

  typedef enum logic [2:0] {
    S_MASK_WR = 3'd0,
    S_IDLE    = 3'd1,
    S_EC_RD   = 3'd2,
    S_EC_CLR  = 3'd3,
    S_DAT_RD  = 3'd4,
    S_PUSH    = 3'd5
  } state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] mask_reg;
  logic             mask_pend;
  logic [WIDTH-1:0] edges_q;
  logic [EW-1:0]    mem [FIFO_DEPTH];
  logic [EW-1:0]    push_dat;
  logic [EW-1:0]    head;
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             push_req, pop, full, accept, drop;

  // Only the low WIDTH bits of the PIO read bus carry button information.
  logic unused_rd;
  assign unused_rd = ^pio_readdata;

  // State register; reset restarts from the mask programming write.
  always_ff @(posedge clk) begin
    if (reset) state <= S_MASK_WR;
    else       state <= state_nx;
  end

  // Next state and Avalon bus decode; bus outputs depend on the state register
  // (and reset, so the bus is released in the cycle reset is asserted).
  always_comb begin
    state_nx       = state;
    pio_chipselect = 1'b0;
    pio_write_n    = 1'b1;
    pio_address    = 2'd0;
    pio_writedata  = 32'd0;
    case (state)
      S_MASK_WR: begin
        state_nx = S_IDLE;
        if (!reset) begin
          pio_chipselect = 1'b1;
          pio_write_n    = 1'b0;
          pio_address    = 2'd2;
          pio_writedata[WIDTH-1:0] = mask_reg;
        end
      end
      S_IDLE: begin
        if (mask_pend)    state_nx = S_MASK_WR;
        else if (pio_irq) state_nx = S_EC_RD;
      end
      S_EC_RD: begin
        state_nx = S_EC_CLR;
        if (!reset) begin
          pio_chipselect = 1'b1;
          pio_address    = 2'd3;
        end
      end
      S_EC_CLR: begin
        state_nx = S_DAT_RD;
        if (!reset) begin
          pio_chipselect = 1'b1;
          pio_write_n    = 1'b0;
          pio_address    = 2'd3;
        end
      end
      S_DAT_RD: begin
        state_nx = S_PUSH;
        if (!reset) begin
          pio_chipselect = 1'b1;
          pio_address    = 2'd0;
        end
      end
      S_PUSH:  state_nx = S_IDLE;
      default: state_nx = S_MASK_WR;
    endcase
  end

  assign busy = !reset && (state != S_IDLE);

  // Mask reprogramming request: last mask_value wins; cleared when the write is issued
  // unless a new request lands in that same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      mask_reg  <= MASK_INIT;
      mask_pend <= 1'b0;
    end else if (mask_load) begin
      mask_reg  <= mask_value;
      mask_pend <= 1'b1;
    end else if (state == S_MASK_WR) begin
      mask_pend <= 1'b0;
    end
  end

  // Capture edge_capture read data (returned the cycle after EC_RD).
  always_ff @(posedge clk) begin
    if (reset)                  edges_q <= '0;
    else if (state == S_EC_CLR) edges_q <= pio_readdata[WIDTH-1:0];
  end

`ifdef BUTTON_SVC_TIMESTAMP_EN
  logic [TS_WIDTH-1:0] ts_cnt, ts_q;

  // Free-running timestamp, sampled when the service read starts.
  always_ff @(posedge clk) begin
    if (reset) begin
      ts_cnt <= '0;
      ts_q   <= '0;
    end else begin
      ts_cnt <= ts_cnt + 1'b1;
      if (state == S_EC_RD) ts_q <= ts_cnt;
    end
  end

  assign push_dat = {edges_q, pio_readdata[WIDTH-1:0], ts_q};
  assign evt_time = head[TS_WIDTH-1:0];
`else
  assign push_dat = {edges_q, pio_readdata[WIDTH-1:0]};
  assign evt_time = '0;
`endif

  // Level data arrives in PUSH; an all-zero edge set is a spurious irq and is not queued.
  assign push_req  = (state == S_PUSH) && (edges_q != '0);
  assign evt_valid = !reset && (count != '0);
  assign pop       = evt_valid && evt_ready;
  assign full      = (count == DEPTH_C);
  assign accept    = push_req && (!full || pop);
  assign drop      = push_req && full && !pop;

  // Event storage; no reset needed, validity is tracked by count.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= push_dat;
  end

  // Pointers, occupancy and saturating drop counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      overflow_cnt <= 8'd0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      case ({accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop && overflow_cnt != 8'hFF) overflow_cnt <= overflow_cnt + 8'd1;
    end
  end

  assign head       = mem[rd_ptr];
`ifdef BUTTON_SVC_TIMESTAMP_EN
  assign evt_edges  = head[EW-1 -: WIDTH];
  assign evt_levels = head[EW-WIDTH-1 -: WIDTH];
`else
  assign evt_edges  = head[EW-1 -: WIDTH];
  assign evt_levels = head[WIDTH-1:0];
`endif

endmodule

// File: tb/tb_sockit_ghrd_button_irq_servicer.sv
// Bench for the button irq servicer: a behavioural button PIO plus an event-queue model.
// Directed steps cover reset, service sequence, FIFO full/overflow, mask reload and mid-service reset.
// Randomized events and pops are scored against a queue model with saturating drop count.
module tb_sockit_ghrd_button_irq_servicer;
  localparam int W   = 4;
  localparam int D   = 8;
  localparam int TSW = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]     pio_address;
  logic           pio_chipselect, pio_write_n;
  logic [31:0]    pio_writedata;
  logic [31:0]    pio_readdata = 32'd0;
  logic           pio_irq;
  logic [W-1:0]   mask_value = '0;
  logic           mask_load = 1'b0;
  logic           evt_valid;
  logic           evt_ready = 1'b0;
  logic [W-1:0]   evt_edges, evt_levels;
  logic [TSW-1:0] evt_time;
  logic [7:0]     overflow_cnt;
  logic           busy;

  sockit_ghrd_button_irq_servicer dut (
    .clk(clk), .reset(reset),
    .pio_address(pio_address), .pio_chipselect(pio_chipselect), .pio_write_n(pio_write_n),
    .pio_writedata(pio_writedata), .pio_readdata(pio_readdata), .pio_irq(pio_irq),
    .mask_value(mask_value), .mask_load(mask_load),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_edges(evt_edges), .evt_levels(evt_levels),
    .evt_time(evt_time), .overflow_cnt(overflow_cnt), .busy(busy)
  );

  // Button PIO model: registered read, any write to edge_capture clears it (clear beats new edges).
  logic [W-1:0] pio_levels = '0;
  logic [W-1:0] pio_mask = '0;
  logic [W-1:0] pio_ec = '0;
  logic [W-1:0] inj = '0;
  int           n_clr_wr = 0;
  logic [31:0]  last_mask_wd = 32'd0;

  assign pio_irq = |(pio_ec & pio_mask);

  always @(posedge clk) begin
    case (pio_address)
      2'd0:    pio_readdata <= {{(32-W){1'b0}}, pio_levels};
      2'd2:    pio_readdata <= {{(32-W){1'b0}}, pio_mask};
      2'd3:    pio_readdata <= {{(32-W){1'b0}}, pio_ec};
      default: pio_readdata <= 32'd0;
    endcase
    if (pio_chipselect && !pio_write_n && pio_address == 2'd3) begin
      pio_ec   <= '0;
      n_clr_wr <= n_clr_wr + 1;
    end else begin
      pio_ec <= pio_ec | inj;
    end
    if (pio_chipselect && !pio_write_n && pio_address == 2'd2) begin
      pio_mask     <= pio_writedata[W-1:0];
      last_mask_wd <= pio_writedata;
    end
  end

  // Reference model: queue of {edges, levels}, capacity D, saturating drop counter.
  typedef struct packed {
    logic [W-1:0] e;
    logic [W-1:0] l;
  } ev_t;
  ev_t q[$];
  int  m_ovf = 0;
  int  n_cmp = 0;
  int  n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic model_event(input logic [W-1:0] e, input logic [W-1:0] l);
    ev_t ev;
    ev.e = e;
    ev.l = l;
    if (q.size() < D) q.push_back(ev);
    else if (m_ovf < 255) m_ovf++;
  endtask

  task automatic pop_one(input string tag);
    chk({tag, "_vld"}, evt_valid, 1'b1);
    chk({tag, "_edges"}, evt_edges, q[0].e);
    chk({tag, "_levels"}, evt_levels, q[0].l);
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    void'(q.pop_front());
  endtask

  // One full service: edge injected, 6 cycles later the servicer is back in IDLE.
  task automatic fire(input logic [W-1:0] e, input logic [W-1:0] l, input bit pop_at_push);
    pio_levels = l;
    inj = e;
    tick();
    inj = '0;
    tick(); tick(); tick(); tick();   // now in PUSH
    if (pop_at_push) begin
      evt_ready = 1'b1;
      if (q.size() > 0) begin
        chk("push_pop_edges", evt_edges, q[0].e);
        chk("push_pop_levels", evt_levels, q[0].l);
        void'(q.pop_front());
      end
    end
    model_event(e, l);
    tick();
    evt_ready = 1'b0;
    chk("svc_idle", busy, 1'b0);
    chk("svc_valid", evt_valid, q.size() != 0);
    chk("svc_ovf", overflow_cnt, m_ovf);
  endtask

  task automatic drain(input string tag);
    while (q.size() > 0) pop_one(tag);
    chk({tag, "_empty"}, evt_valid, 1'b0);
  endtask

  initial begin
    logic [W-1:0]   e, l;
    logic [TSW-1:0] t1, t2;

    // Reset state
    tick(); tick();
    chk("rst_cs", pio_chipselect, 1'b0);
    chk("rst_wn", pio_write_n, 1'b1);
    chk("rst_addr", pio_address, 2'd0);
    chk("rst_wdata", pio_writedata, 32'd0);
    chk("rst_valid", evt_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ovf", overflow_cnt, 8'd0);

    // Release: mask write first, then IDLE
    reset = 1'b0;
    #1;
    chk("mwr_cs", pio_chipselect, 1'b1);
    chk("mwr_wn", pio_write_n, 1'b0);
    chk("mwr_addr", pio_address, 2'd2);
    chk("mwr_wdata", pio_writedata, 32'hF);
    tick();
    chk("idle_busy", busy, 1'b0);
    chk("idle_cs", pio_chipselect, 1'b0);
    chk("pio_mask_init", pio_mask, 4'hF);

    // Single event: latency and bus sequence
    pio_levels = 4'hA;
    inj = 4'h5;
    tick();
    inj = '0;
    chk("t2_irq", pio_irq, 1'b1);
    chk("t2_v0", evt_valid, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk("t2_latency", evt_valid, k == 5);
      if (k == 1) begin
        chk("ecrd_cs", pio_chipselect, 1'b1);
        chk("ecrd_wn", pio_write_n, 1'b1);
        chk("ecrd_addr", pio_address, 2'd3);
      end
      if (k == 2) begin
        chk("ecclr_wn", pio_write_n, 1'b0);
        chk("ecclr_addr", pio_address, 2'd3);
        chk("ecclr_wdata", pio_writedata, 32'd0);
      end
      if (k == 3) chk("datrd_addr", pio_address, 2'd0);
    end
    chk("t2_clr_seen", n_clr_wr, 1);
    chk("t2_ec_cleared", pio_ec, 4'h0);
    chk("t2_edges", evt_edges, 4'h5);
    chk("t2_levels", evt_levels, 4'hA);
`ifndef BUTTON_SVC_TIMESTAMP_EN
    chk("t2_time0", evt_time, 16'd0);
`endif
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    chk("t2_popped", evt_valid, 1'b0);

    // Fill to 8, then one drop
    for (int i = 0; i < D; i++) fire(W'($urandom_range(1, 15)), W'($urandom_range(0, 15)), 1'b0);
    chk("t3_full_ovf", overflow_cnt, 8'd0);
    fire(W'($urandom_range(1, 15)), W'($urandom_range(0, 15)), 1'b0);
    chk("t3_first_drop", overflow_cnt, 8'd1);

    // Full FIFO with a pop in the PUSH cycle: accepted, no drop
    fire(W'($urandom_range(1, 15)), W'($urandom_range(0, 15)), 1'b1);
    chk("t4_ovf_same", overflow_cnt, 8'd1);

    // Saturation of the drop counter
    for (int i = 0; i < 299; i++) fire(W'($urandom_range(1, 15)), W'($urandom_range(0, 15)), 1'b0);
    chk("t3_sat", overflow_cnt, 8'd255);
    drain("t34_drain");

    // Mask reload during EC_CLR with irq staying high
    l = W'($urandom_range(0, 15));
    pio_levels = l;
    inj = 4'h1;
    tick();
    inj = '0;
    tick(); tick();                           // EC_CLR
    mask_value = 4'h3;
    mask_load = 1'b1;
    tick();                                   // DAT_RD
    mask_load = 1'b0;
    inj = 4'h2;
    tick();                                   // PUSH
    inj = '0;
    model_event(4'h1, l);
    tick();                                   // IDLE
    chk("t5_idle", busy, 1'b0);
    tick();                                   // MASK_WR
    chk("t5_mwr_cs", pio_chipselect, 1'b1);
    chk("t5_mwr_wn", pio_write_n, 1'b0);
    chk("t5_mwr_addr", pio_address, 2'd2);
    chk("t5_mwr_wdata", pio_writedata, 32'h3);
    tick();                                   // IDLE
    chk("t5_pio_mask", last_mask_wd, 32'h3);
    chk("t5_irq_high", pio_irq, 1'b1);
    tick();                                   // EC_RD
    chk("t5_ecrd_addr", pio_address, 2'd3);
    chk("t5_ecrd_wn", pio_write_n, 1'b1);
    tick(); tick(); tick(); tick();           // back to IDLE
    model_event(4'h2, l);
    chk("t5_done", busy, 1'b0);
    drain("t5_drain");

    // Reset during DAT_RD with one event queued
    fire(4'h1, 4'h6, 1'b0);
    chk("t6_queued", evt_valid, 1'b1);
    inj = 4'h2;
    tick();
    inj = '0;
    tick(); tick(); tick();                   // DAT_RD
    chk("t6_datrd_cs", pio_chipselect, 1'b1);
    reset = 1'b1;
    #1;
    chk("t6_rst_cs", pio_chipselect, 1'b0);
    chk("t6_rst_wn", pio_write_n, 1'b1);
    chk("t6_rst_busy", busy, 1'b0);
    chk("t6_rst_valid", evt_valid, 1'b0);
    tick(); tick();
    reset = 1'b0;
    #1;
    q.delete();
    m_ovf = 0;
    chk("t6_mwr_addr", pio_address, 2'd2);
    chk("t6_mwr_wdata", pio_writedata, 32'hF);
    tick();
    chk("t6_empty", evt_valid, 1'b0);
    chk("t6_ovf0", overflow_cnt, 8'd0);
    chk("t6_mask_back", pio_mask, 4'hF);

    // Randomized events, pops at PUSH and in between
    for (int i = 0; i < 60; i++) begin
      e = W'($urandom_range(1, 15));
      l = W'($urandom_range(0, 15));
      fire(e, l, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0 && q.size() > 0) pop_one("rnd_pop");
    end
    drain("rnd_drain");

`ifdef BUTTON_SVC_TIMESTAMP_EN
    // Two irqs 20 cycles apart
    fire(4'h1, 4'h0, 1'b0);
    t1 = evt_time;
    pop_one("ts1");
    for (int i = 0; i < 13; i++) tick();
    fire(4'h2, 4'h0, 1'b0);
    t2 = evt_time;
    chk("ts_delta", TSW'(t2 - t1), 16'd20);
    pop_one("ts2");
`else
    t1 = '0;
    t2 = '0;
    fire(4'h4, 4'h9, 1'b0);
    chk("time_tied0", evt_time, 32'(t2 - t1));
    pop_one("notime");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
